// File: rtl/rf_pkg.sv
// Shared types and defaults for the busy-scoreboarded integer register file.
package rf_pkg;

  localparam int XLEN_DEFAULT     = 32;
  localparam int RF_DEPTH_DEFAULT = 32;
  localparam int REG_ZERO         = 0;

  typedef logic [XLEN_DEFAULT-1:0] xlen_t;
  typedef logic [4:0]              reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits (set at issue, cleared at writeback, squashed by flush)
// plus the registered WAW-on-issue error pulse.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DEPTH    = RF_DEPTH_DEFAULT,
  parameter int NUM_READ = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_rd,
  input  logic                   wb_en,
  input  logic [AW-1:0]          wb_rd,
  input  logic                   flush,
  input  logic [NUM_READ*AW-1:0] rs_address,
  output logic [NUM_READ-1:0]    rs_busy,
  output logic                   waw_err
);

  // issue_en and wb_en are single-cycle strobes with no backpressure:
  // each is consumed on the rising edge where it is high, never stalled.
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             waw_d;

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wb_en && wb_rd != AW'(REG_ZERO)) busy_d[wb_rd] = 1'b0;
      // A new producer supersedes a same-cycle writeback, so issue is applied last.
      if (issue_en && issue_rd != AW'(REG_ZERO)) busy_d[issue_rd] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  assign waw_d = issue_en && !flush && (issue_rd != AW'(REG_ZERO)) && busy_q[issue_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      waw_err <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      waw_err <= waw_d;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_busy_rd
    assign rs_busy[i] = busy_q[rs_address[i*AW +: AW]];
  end

endmodule

// File: rtl/register_file_sb.sv
// Parametrised multi-read, single-write register file with hardwired-zero x0 and a
// RAW scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module register_file_sb
  import rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int DEPTH    = RF_DEPTH_DEFAULT,
  parameter int NUM_READ = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [AW-1:0]            rd,
  input  logic [XLEN-1:0]          register_file_data,
  input  logic [NUM_READ*AW-1:0]   rs_address,
  output logic [NUM_READ*XLEN-1:0] rs_data,
  output logic [NUM_READ-1:0]      rs_busy,
  input  logic                     issue_en,
  input  logic [AW-1:0]            issue_rd,
  input  logic                     flush,
  output logic                     waw_err
);

  logic [XLEN-1:0]     regs [DEPTH];
  logic [NUM_READ-1:0] sb_busy;
  logic                wr_live;

  assign wr_live = en && (rd != AW'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else if (wr_live) begin
      regs[rd] <= register_file_data;
    end
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .NUM_READ (NUM_READ)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .wb_en      (en),
    .wb_rd      (rd),
    .flush      (flush),
    .rs_address (rs_address),
    .rs_busy    (sb_busy),
    .waw_err    (waw_err)
  );

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] stored;
    logic            hit;

    assign addr   = rs_address[i*AW +: AW];
    assign stored = (addr == AW'(REG_ZERO)) ? '0 : regs[addr];
`ifdef REGFILE_BYPASS_EN
    assign hit = wr_live && (rd == addr);
`else
    assign hit = 1'b0;
`endif
    // A forwarded value is available now, so its port no longer reports busy.
    assign rs_data[i*XLEN +: XLEN] = hit ? register_file_data : stored;
    assign rs_busy[i]              = sb_busy[i] && !hit;
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: directed steps followed by random traffic,
// each compared against an array-based reference model of the register file.
module tb_register_file_sb;
  import rf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [4:0]  rd;
  xlen_t       wdata;
  logic [9:0]  rs_address;
  logic [63:0] rs_data;
  logic [1:0]  rs_busy;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        flush;
  logic        waw_err;

  int n_cmp  = 0;
  int n_fail = 0;

  xlen_t       m_regs [32];
  bit          m_busy [32];
  logic [0:0]  exp_q [$];

  register_file_sb dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .en                 (en),
    .rd                 (rd),
    .register_file_data (wdata),
    .rs_address         (rs_address),
    .rs_data            (rs_data),
    .rs_busy            (rs_busy),
    .issue_en           (issue_en),
    .issue_rd           (issue_rd),
    .flush              (flush),
    .waw_err            (waw_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    exp_q.delete();
  endtask

  function automatic bit fwd_hit(input int a);
`ifdef REGFILE_BYPASS_EN
    return en && (rd != 0) && (int'(rd) == a);
`else
    return 1'b0;
`endif
  endfunction

  function automatic xlen_t exp_data(input int a);
    if (a == 0) return '0;
    if (fwd_hit(a)) return wdata;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input int a);
    if (a == 0 || fwd_hit(a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic set_idle();
    en = 1'b0; rd = '0; wdata = '0;
    issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
  endtask

  task automatic set_ports(input int a0, input int a1);
    rs_address[4:0] = 5'(a0);
    rs_address[9:5] = 5'(a1);
  endtask

  // One clock: advance the model with the inputs held across the edge, then check waw_err.
  task automatic tick();
    @(posedge clk);
    exp_q.push_back(issue_en && !flush && (issue_rd != 0) && m_busy[issue_rd]);
    if (en && rd != 0) m_regs[rd] = wdata;
    if (flush) begin
      for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    end else begin
      if (en && rd != 0) m_busy[rd] = 1'b0;
      if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
    #1;
    chk("waw_err", 32'(waw_err), 32'(exp_q.pop_front()));
  endtask

  task automatic check_ports(input string tag);
    int a;
    #1;
    for (int i = 0; i < 2; i++) begin
      a = int'(rs_address[i*5 +: 5]);
      chk($sformatf("%s_data%0d_x%0d", tag, i, a), rs_data[i*32 +: 32], exp_data(a));
      chk($sformatf("%s_busy%0d_x%0d", tag, i, a), 32'(rs_busy[i]), 32'(exp_busy(a)));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    set_ports(0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state: every register reads zero and idle.
    chk("rst_waw", 32'(waw_err), 32'd0);
    for (int a = 0; a < 32; a++) begin
      set_ports(a, 31 - a);
      check_ports("rst");
      chk("rst_lit", rs_data[31:0], 32'd0);
    end

    // Write then read back; writes to x0 are dropped.
    en = 1'b1; rd = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    set_idle(); set_ports(5, 0);
    check_ports("wr5");
    chk("wr5_lit", rs_data[31:0], 32'hDEADBEEF);
    en = 1'b1; rd = 5'd0; wdata = 32'h1234;
    tick();
    set_idle(); set_ports(0, 5);
    check_ports("wr0");
    chk("x0_lit", rs_data[31:0], 32'd0);

    // Issue marks busy; writeback clears it and lands data.
    issue_en = 1'b1; issue_rd = 5'd7;
    tick();
    set_idle(); set_ports(0, 7);
    check_ports("iss7");
    chk("iss7_busy_lit", 32'(rs_busy[1]), 32'd1);
    en = 1'b1; rd = 5'd7; wdata = 32'hA5;
    tick();
    set_idle(); set_ports(7, 7);
    check_ports("wb7");
    chk("wb7_busy_lit", 32'(rs_busy[1]), 32'd0);
    chk("wb7_data_lit", rs_data[63:32], 32'hA5);

    // Issue beats a same-cycle writeback to an already-busy register.
    issue_en = 1'b1; issue_rd = 5'd9;
    tick();
    en = 1'b1; rd = 5'd9; wdata = 32'h99;
    issue_en = 1'b1; issue_rd = 5'd9;
    tick();
    chk("x9_waw_lit", 32'(waw_err), 32'd1);
    set_idle(); set_ports(9, 9);
    check_ports("x9");
    chk("x9_busy_lit", 32'(rs_busy[0]), 32'd1);
    chk("x9_data_lit", rs_data[31:0], 32'h99);

    // WAW pulse on back-to-back issue, then flush squashing a same-cycle issue.
    issue_en = 1'b1; issue_rd = 5'd3;
    tick();
    chk("waw_first_lit", 32'(waw_err), 32'd0);
    tick();
    chk("waw_second_lit", 32'(waw_err), 32'd1);
    set_idle();
    tick();
    chk("waw_drop_lit", 32'(waw_err), 32'd0);
    flush = 1'b1; issue_en = 1'b1; issue_rd = 5'd4;
    tick();
    chk("flush_waw_lit", 32'(waw_err), 32'd0);
    set_idle(); set_ports(4, 3);
    check_ports("flush");
    chk("flush_b4_lit", 32'(rs_busy[0]), 32'd0);
    chk("flush_b3_lit", 32'(rs_busy[1]), 32'd0);

    // Same-cycle write and read of x12.
    issue_en = 1'b1; issue_rd = 5'd12;
    tick();
    set_idle();
    en = 1'b1; rd = 5'd12; wdata = 32'h55; set_ports(12, 12);
    check_ports("byp");
`ifdef REGFILE_BYPASS_EN
    chk("byp_data_lit", rs_data[31:0], 32'h55);
    chk("byp_busy_lit", 32'(rs_busy[0]), 32'd0);
`else
    chk("byp_data_lit", rs_data[31:0], 32'd0);
    chk("byp_busy_lit", 32'(rs_busy[0]), 32'd1);
`endif
    tick();
    set_idle();
    check_ports("byp_after");

    // Random traffic over a narrow address window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      en       = 1'($urandom_range(0, 1));
      rd       = 5'($urandom_range(0, 7));
      wdata    = $urandom;
      issue_en = 1'($urandom_range(0, 1));
      issue_rd = 5'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 15) == 0);
      set_ports($urandom_range(0, 7), $urandom_range(0, 7));
      check_ports("rnd");
      tick();
    end

    // Asynchronous reset mid-operation, held across an edge carrying a write.
    set_idle();
    en = 1'b1; rd = 5'd5; wdata = 32'hCAFEF00D;
    issue_en = 1'b1; issue_rd = 5'd6;
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_waw", 32'(waw_err), 32'd0);
    set_idle();
    for (int a = 0; a < 8; a++) begin
      set_ports(a, 7 - a);
      check_ports("arst");
    end
    en = 1'b1; rd = 5'd5; wdata = 32'h11111111;
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_idle(); set_ports(5, 6);
    check_ports("post_rst");
    chk("post_rst_x5_lit", rs_data[31:0], 32'd0);
    chk("post_rst_b6_lit", 32'(rs_busy[1]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the single-write, dual-read integer register file.
- Provides NUM_READ asynchronous read ports, one synchronous write port and a hardwired-zero x0.
- Adds a per-register busy scoreboard: bits are set at issue and cleared at writeback. Decode uses them to detect RAW hazards.
- Sits between the ID stage (read, issue) and the WB stage (write, clear).

Parameters:
- XLEN, 32, data width of each register.
- DEPTH, 32, number of architectural registers; must be a power of 2 and at least 2.
- NUM_READ, 2, number of independent read ports; range 1..4.
- AW, $clog2(DEPTH), address width; localparam, not overridable.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  write enable from WB.
- rd  in  AW  write destination address.
- register_file_data  in  XLEN  write data.
- rs_address  in  NUM_READ*AW  packed read addresses; port i occupies bits [i*AW +: AW].
- rs_data  out  NUM_READ*XLEN  packed read data.
- rs_busy  out  NUM_READ  per-port flag: the addressed register has a pending producer.
- issue_en  in  1  ID stage issues an instruction that writes a register.
- issue_rd  in  AW  destination of the issued instruction.
- flush  in  1  synchronous clear of all busy bits (branch or exception squash).
- waw_err  out  1  registered pulse: issue targeted a register that was already busy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All DEPTH registers are cleared to 0.
  - All busy bits are cleared.
  - waw_err = 0.
  - rs_data and rs_busy then reflect zeros.
- Write:
  - At posedge, if en=1 and rd!=0, regs[rd] <= register_file_data.
  - A write to x0 is silently dropped.
- Read:
  - Combinational with zero latency: rs_data[i] = regs[rs_address[i]].
  - Address 0 always returns 0 and rs_busy = 0.
- Busy update, per register r!=0 at posedge:
  - flush=1: busy <= 0 for all r. Any issue in the same cycle is ignored.
  - else issue_en=1 and issue_rd==r: busy[r] <= 1. Issue wins over a same-cycle writeback to the same r, because the new producer supersedes the old one.
  - else en=1 and rd==r: busy[r] <= 0.
  - otherwise: hold.
- issue_rd=0 never sets a busy bit.
- rs_busy[i] = busy[rs_address[i]], combinational.
- waw_err:
  - Asserts for exactly one cycle when, at a posedge, issue_en=1, issue_rd!=0, busy[issue_rd]=1 and flush=0.
  - Otherwise it is 0.
- Multiple read ports may address the same register; each returns identical data.
- Reset asserted mid-operation discards all pending state; no partial writes complete.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding. If en=1, rd!=0 and rd==rs_address[i], then rs_data[i] = register_file_data in the same cycle.
  - rs_busy[i] is then forced to 0 for that port, because the data is available.
- Undefined:
  - Reads return the pre-write value until the next cycle.
  - rs_busy reflects the stored busy bit only.

Decomposition:
- Shared package rf_pkg holds:
  - XLEN_DEFAULT = 32 and RF_DEPTH_DEFAULT = 32.
  - typedef logic [XLEN-1:0] xlen_t.
  - typedef logic [4:0] reg_addr_t.
  - localparam REG_ZERO = 0.
- One natural sub-module: rf_scoreboard.
  - Contains the busy bit-vector, flush/issue/clear priority and waw_err generation.
  - Parametrised by DEPTH and NUM_READ.
  - Instantiated once; the data array stays in the top module.

Test Plan:
- Reset: hold rst_n=0, then release. All rs_address values 0..31 read 0 with rs_busy=0, and waw_err=0.
- Write/read: en=1, rd=5, data=0xDEADBEEF. Next cycle rs_address[0]=5 gives 0xDEADBEEF. Write rd=0, data=0x1234; reading x0 gives 0.
- Scoreboard: issue_rd=7, then rs_address[1]=7 gives rs_busy[1]=1. WB en=1, rd=7, data=0xA5 gives busy 0 and data 0xA5 next cycle.
- Same-cycle issue and WB to x9, with busy[9] initially 1: after the edge busy[9] remains 1 and regs[9] is updated.
- WAW and flush:
  - Issue x3 twice in consecutive cycles: waw_err pulses exactly one cycle after the second issue.
  - Then flush=1 clears all busy bits. A same-cycle issue of x4 leaves busy[4]=0.
- Bypass (with REGFILE_BYPASS_EN): en=1, rd=12, data=0x55, rs_address[0]=12 in the same cycle gives rs_data[0]=0x55 combinationally. Without the macro, the old value is returned.
